// File: rtl/fifo_bulk_reader.sv
// Bulk reader: waits for a full bulk in the FIFO, then streams exactly one
// bulk out as a valid/ready stream with a last-word marker.
module fifo_bulk_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BULK_OF_DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_r_ready,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [31:0]           burst_count,
    output logic                  error_underrun
);

    localparam int CW = $clog2(BULK_OF_DATA + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [31:0]           burst_count_q, burst_count_d;
    logic                  error_underrun_q, error_underrun_d;
    logic                  free;
    logic                  want;
    logic                  rd_en;

    always_comb begin
        state_d          = state_q;
        remaining_d      = remaining_q;
        m_data_d         = m_data_q;
        m_valid_d        = m_valid_q;
        m_last_d         = m_last_q;
        burst_count_d    = burst_count_q;
        error_underrun_d = error_underrun_q;
        free             = !m_valid_q || m_ready;
        want             = 1'b0;
        rd_en            = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable && fifo_r_ready) begin
                    remaining_d = CW'(BULK_OF_DATA);
                    state_d     = BURST;
                end
            end
            BURST: begin
                want  = free && (remaining_q != '0);
                rd_en = want && !fifo_empty && !rst;
                if (rd_en) begin
                    m_data_d    = fifo_rdata;
                    m_valid_d   = 1'b1;
                    m_last_d    = (remaining_q == CW'(1));
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    // Starved while the slot is free: flag it and wait.
                    if (want) begin
                        error_underrun_d = 1'b1;
                    end
                    if (free) begin
                        m_valid_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    m_valid_d     = 1'b0;
                    m_last_d      = 1'b0;
                    burst_count_d = burst_count_q + 32'd1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            remaining_q      <= '0;
            m_data_q         <= '0;
            m_valid_q        <= 1'b0;
            m_last_q         <= 1'b0;
            burst_count_q    <= '0;
            error_underrun_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            remaining_q      <= remaining_d;
            m_data_q         <= m_data_d;
            m_valid_q        <= m_valid_d;
            m_last_q         <= m_last_d;
            burst_count_q    <= burst_count_d;
            error_underrun_q <= error_underrun_d;
        end
    end

    assign fifo_r_enable  = rd_en;
    assign m_data         = m_data_q;
    assign m_valid        = m_valid_q;
    assign m_last         = m_last_q;
    assign busy           = (state_q != IDLE) && !rst;
    assign burst_count    = burst_count_q;
    assign error_underrun = error_underrun_q;

endmodule

// File: doc/fifo_bulk_reader.md
Name: fifo_bulk_reader

Overview:
- Downstream consumer of the bulk FIFO.
- Waits for the FIFO to report that a full bulk (BULK_OF_DATA words) is buffered, then reads exactly one bulk and presents it as a valid/ready stream with a last-word marker.
- Handles output backpressure, counts completed bulks, and flags FIFO underrun.
- Sits between the FIFO read side and packet/DMA logic, all in the FIFO read clock domain.

Parameters:
- DATA_WIDTH, 32, width of the FIFO word and of m_data.
- BULK_OF_DATA, 8, words per burst; must be >= 1 and must equal the FIFO's bulk size.

Ports:
- clk  in  1  read-side clock; same net as the FIFO read clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits starting a new burst; sampled only in IDLE.
- fifo_r_ready  in  1  FIFO holds at least BULK_OF_DATA words.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_WIDTH  FIFO read data.
- fifo_r_enable  out  1  FIFO read strobe; combinational from state, counter and handshakes.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accepts m_data.
- m_last  out  1  marks the final word of a burst.
- busy  out  1  high whenever state != IDLE.
- burst_count  out  32  number of completed bursts; wraps 0xFFFFFFFF -> 0.
- error_underrun  out  1  sticky underrun flag.

Behaviour:
- Reset is synchronous and active-high: clk is the single clock, rst resets synchronously.
  - Reset values: m_data=0, m_valid=0, m_last=0, burst_count=0, error_underrun=0, state=IDLE, remaining=0.
  - busy=0 and fifo_r_enable=0 while rst is high.
  - Reset mid-burst abandons the burst immediately; no partial m_last is emitted.
- FIFO read timing:
  - The FIFO updates fifo_rdata on the falling edge of clk when its read enable is high.
  - This block captures fifo_rdata at the rising edge that ends the cycle in which fifo_r_enable was high.
  - Zero added latency: the word appears on m_data with m_valid=1 in the next cycle.
- Output slot:
  - free = !m_valid || m_ready.
  - A transfer occurs when m_valid && m_ready.
  - m_data and m_last are held stable while m_valid && !m_ready.
- remaining counter: width clog2(BULK_OF_DATA+1), counts words still to read in the current burst.
- State machine:
  - IDLE:
    - fifo_r_enable=0.
    - If enable && fifo_r_ready: load remaining=BULK_OF_DATA and go to BURST.
  - BURST:
    - want = free && remaining != 0.
    - fifo_r_enable = want && !fifo_empty.
    - On each read: m_data <= fifo_rdata, m_valid <= 1, m_last <= (remaining==1), remaining decrements.
    - If want && fifo_empty: no read; set error_underrun (sticky until rst); stay in BURST until data arrives.
    - If free but no read this cycle: m_valid <= 0.
    - When the read with remaining==1 occurs, go to DRAIN.
  - DRAIN:
    - fifo_r_enable=0.
    - On a transfer with m_last=1: m_valid <= 0, m_last <= 0, burst_count increments, go to IDLE.
- Throughput:
  - One word per cycle while m_ready is held high.
  - At least 2 idle cycles between bursts (the DRAIN-to-IDLE and IDLE-to-BURST decisions).
- Boundary cases:
  - enable dropping mid-burst does not stop the burst; it only blocks the next start.
  - fifo_r_ready is ignored outside IDLE.
  - BULK_OF_DATA=1: the single word carries m_last=1.
  - Simultaneous transfer and read in BURST is legal and yields back-to-back words.
  - Exactly BULK_OF_DATA reads per burst, never more. fifo_r_enable is never high in IDLE or DRAIN.

Test Plan:
1. Reset, enable=1, FIFO preloaded with 8 words 0x10..0x17, m_ready=1 -> 8 consecutive m_valid cycles carrying 0x10..0x17; m_last only on 0x17; burst_count=1; exactly 8 fifo_r_enable pulses.
2. Same stimulus with m_ready toggling 1,0,1,0 -> m_data held during stalls, no word lost or duplicated, fifo_r_enable low whenever the slot is occupied and unaccepted, burst_count=1.
3. 16 words preloaded, m_ready=1 -> two bursts; two m_last pulses on words 8 and 16; burst_count=2; a gap of at least 2 cycles between bursts.
4. Force fifo_empty=1 for 3 cycles after the 4th read -> error_underrun=1 and stays set; reads resume when fifo_empty=0; burst completes with 8 words and m_last on the 8th.
5. Clear enable after the 3rd word -> burst still completes all 8 words; no new burst while enable=0 even with fifo_r_ready=1.
6. Assert rst after the 5th word -> the next cycle shows m_valid=0, busy=0, burst_count unchanged from before reset was applied to 0, error_underrun=0, and no m_last emitted.
